clk_period_meter: RTL and testbench

Receive-side counterpart of the clock divider. It samples a slow, possibly asynchronous periodic signal (for example a divided clock output) in the fast `clk_in` domain. For each full cycle of that signal it measures the period and the high time in `clk_in` cycles. Used in self-check and bring-up logic to confirm divider ratios and duty cycle at runtime.

---
 rtl/clk_period_meter.sv | 122 ++++++++++++
 tb/tb_clk_period_meter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - measures period and high time of a slow signal in clk_in cycles
// Synchronizes sig_in, detects edges, and reports per-cycle period/high time with a sticky timeout.
module clk_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       hcnt_q, hcnt_d;
    logic                   in_high_q, in_high_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [WIDTH-1:0]       high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    logic s;
    logic rise;
    logic fall;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d      = s;
        state_d     = state_q;
        cnt_d       = cnt_q;
        hcnt_d      = hcnt_q;
        in_high_d   = in_high_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                // Arming rise only starts a measurement; timeout stays until a real result
                if (rise) begin
                    state_d   = MEASURE;
                    cnt_d     = CNT_ONE;
                    hcnt_d    = CNT_ONE;
                    in_high_d = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d    = cnt_q;
                    high_time_d = hcnt_q;
                    valid_d     = 1'b1;
                    timeout_d   = 1'b0;
                    cnt_d       = CNT_ONE;
                    hcnt_d      = CNT_ONE;
                    in_high_d   = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    timeout_d = 1'b1;
                    in_high_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (fall) begin
                        in_high_d = 1'b0;
                    end else if (in_high_q && (hcnt_q != CNT_MAX)) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            hcnt_q      <= '0;
            in_high_q   <= 1'b0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            hcnt_q      <= hcnt_d;
            in_high_q   <= in_high_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - scoreboard bench for clk_period_meter (WIDTH 16 and WIDTH 4 units)
// Expected results come from edge times of the driven waveform; a monitor pops them on valid.
module tb_clk_period_meter;

    logic        clk = 1'b0;
    logic        rst0 = 1'b0, rst1 = 1'b0;
    logic        sig0 = 1'b0, sig1 = 1'b0;
    logic [15:0] period0, high0;
    logic [3:0]  period1, high1;
    logic        valid0, valid1, timeout0, timeout1;

    clk_period_meter #(.WIDTH(16), .SYNC_STAGES(2)) dut0 (
        .clk_in(clk), .rst_n(rst0), .sig_in(sig0),
        .period(period0), .high_time(high0), .valid(valid0), .timeout(timeout0)
    );

    clk_period_meter #(.WIDTH(4), .SYNC_STAGES(2)) dut1 (
        .clk_in(clk), .rst_n(rst1), .sig_in(sig1),
        .period(period1), .high_time(high1), .valid(valid1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int high;
        int vcyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   maxc[2] = '{65535, 15};
    bit   armed[2] = '{0, 0};
    bit   cur[2] = '{0, 0};
    int   last_rise[2] = '{0, 0};
    int   last_fall[2] = '{0, 0};
    logic pv0 = 1'b0, pv1 = 1'b0;

    localparam int LATENCY = 3;

    always @(posedge clk) cyc++;

    task automatic cmp(input string name, input int u, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s unit%0d at cycle %0d: got %0d, expected %0d", name, u, cyc, act, exp);
        end
    endtask

    // Reference model: a result exists for each pair of consecutive rises no further apart than max count
    task automatic model_rise(input int u, input int c);
        exp_t e;
        if (armed[u] && (c - last_rise[u]) <= maxc[u]) begin
            e.period = c - last_rise[u];
            e.high   = last_fall[u] - last_rise[u];
            e.vcyc   = c + LATENCY;
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        last_rise[u] = c;
        armed[u]     = 1'b1;
    endtask

    task automatic set_sig(input int u, input bit v);
        if (v && !cur[u]) model_rise(u, cyc);
        if (!v && cur[u]) last_fall[u] = cyc;
        cur[u] = v;
        if (u == 0) sig0 = v;
        else        sig1 = v;
    endtask

    task automatic pulse(input int u, input int h, input int l);
        set_sig(u, 1'b1);
        repeat (h) @(negedge clk);
        set_sig(u, 1'b0);
        repeat (l) @(negedge clk);
    endtask

    task automatic check_out(input int u, input logic v, input logic pv, input int per,
                             input int ht, input logic to);
        exp_t e;
        if (!v) return;
        n_chk++;
        if (pv) begin
            n_fail++;
            $display("FAIL valid_back_to_back unit%0d at cycle %0d: got 1, expected 0", u, cyc);
        end
        n_chk++;
        if ((u == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_fail++;
            $display("FAIL unexpected_valid unit%0d at cycle %0d: got valid=1, expected none", u, cyc);
            return;
        end
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        cmp("period", u, per, e.period);
        cmp("high_time", u, ht, e.high);
        cmp("valid_cycle", u, cyc, e.vcyc);
        cmp("timeout_clear_on_valid", u, int'(to), 0);
    endtask

    always @(negedge clk) begin
        check_out(0, valid0, pv0, int'(period0), int'(high0), timeout0);
        check_out(1, valid1, pv1, int'(period1), int'(high1), timeout1);
        pv0 = valid0;
        pv1 = valid1;
    end

    initial begin
        repeat (3) @(negedge clk);
        cmp("reset_period", 0, int'(period0), 0);
        cmp("reset_high_time", 0, int'(high0), 0);
        cmp("reset_valid", 0, int'(valid0), 0);
        cmp("reset_timeout", 0, int'(timeout0), 0);
        cmp("reset_period", 1, int'(period1), 0);
        cmp("reset_timeout", 1, int'(timeout1), 0);
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(negedge clk);

        // 3/3 toggling, duty change, fastest toggle, then random cycles
        repeat (5) pulse(0, 3, 3);
        pulse(0, 2, 8);
        pulse(0, 7, 3);
        repeat (8) pulse(0, 1, 1);
        repeat (25) pulse(0, $urandom_range(1, 12), $urandom_range(1, 12));

        // Asynchronous reset during a high phase, released while sig_in is still high
        set_sig(0, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst0 = 1'b0;
        #1;
        cmp("async_reset_period", 0, int'(period0), 0);
        cmp("async_reset_high_time", 0, int'(high0), 0);
        cmp("async_reset_valid", 0, int'(valid0), 0);
        cmp("async_reset_timeout", 0, int'(timeout0), 0);
        @(negedge clk);
        rst0     = 1'b1;
        armed[0] = 1'b0;
        model_rise(0, cyc);
        repeat (2) @(negedge clk);
        set_sig(0, 1'b0);
        repeat (3) @(negedge clk);
        repeat (3) pulse(0, 3, 3);

        // WIDTH=4 unit: establish a result, then starve it into timeout
        pulse(1, 3, 3);
        pulse(1, 3, 3);
        set_sig(1, 1'b1);
        repeat (3) @(negedge clk);
        set_sig(1, 1'b0);
        repeat (14) @(negedge clk);
        cmp("timeout_not_yet", 1, int'(timeout1), 0);
        @(negedge clk);
        cmp("timeout_set", 1, int'(timeout1), 1);
        cmp("timeout_keeps_period", 1, int'(period1), 6);
        cmp("timeout_keeps_high_time", 1, int'(high1), 3);
        repeat (2) @(negedge clk);
        set_sig(1, 1'b1);
        repeat (3) @(negedge clk);
        cmp("timeout_held_after_arm", 1, int'(timeout1), 1);
        set_sig(1, 1'b0);
        repeat (3) @(negedge clk);
        pulse(1, 3, 3);
        pulse(1, 3, 3);
        cmp("timeout_cleared", 1, int'(timeout1), 0);

        repeat (10) @(negedge clk);
        cmp("scoreboard_drained", 0, q0.size(), 0);
        cmp("scoreboard_drained", 1, q1.size(), 0);
        cmp("no_timeout_wide", 0, int'(timeout0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
